fir_frame_buffer: RTL
=====================

Name: fir_frame_buffer

Overview:
Downstream stage of the FIR filter. Collects the FIR output stream (fir_d qualified by fir_valid) into 16-sample frames for the following 16-point FFT. Two frame banks are used in ping-pong fashion, so the FIR stream continues while the FFT consumes the previous frame. A frame is handed to the FFT over a valid/ready handshake.

Parameters:
DATA_W, 16, sample width in bits (signed two's complement)
FRAME_LEN, 16, samples per frame; must be a power of 2, minimum 2
LOG2_LEN, 4, log2(FRAME_LEN); index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
fir_valid  input  1  fir_d carries a valid sample this cycle
fir_d  input  DATA_W  signed sample from the FIR
frame_ready  input  1  FFT accepts the presented frame this cycle
frame_valid  output  1  a complete frame is presented on frame_data
frame_data  output  DATA_W*FRAME_LEN  flattened frame; slot i is at bits [i*DATA_W +: DATA_W]
overflow  output  1  sticky: a sample was dropped because both banks were full

Behaviour:
- Reset (async, rst=1): both banks empty; write bank = 0; read bank = 0; write index = 0; frame_valid=0; overflow=0; frame_data=0.
- Bank state: each bank has a full flag. Write bank receives samples; read bank is presented to the FFT.
- Sample acceptance: at a rising edge with fir_valid=1 and the write bank not full, fir_d is stored at slot wr_idx and wr_idx increments.
- Frame completion: when wr_idx==FRAME_LEN-1 and a sample is accepted:
  - the write bank's full flag sets;
  - wr_idx wraps to 0;
  - the write bank toggles to the other bank.
- Latency: frame_valid rises on the edge that stores the 16th sample. It is a registered output with no combinational path from fir_valid.
- Backpressure: if the write bank is full (both banks full), an arriving fir_valid sample is dropped, wr_idx holds, and overflow sets. overflow clears only on rst.
- Handshake:
  - frame_valid = read bank full.
  - frame_data shows the read bank contents, registered, and is stable while frame_valid=1 and frame_ready=0.
  - On an edge with frame_valid && frame_ready, the read bank is cleared to empty and the read bank toggles.
  - frame_valid is 1 in the next cycle if the other bank is already full; otherwise it is 0.
- Simultaneous events:
  - Handshake on bank A and completion of bank B in the same cycle: both take effect; frame_valid stays 1 and frame_data switches to B.
  - Handshake freeing the bank that is also the write target while a sample arrives: the sample is dropped and overflow sets. The free-up becomes visible the cycle after.
- Gaps: fir_valid may drop mid-frame. The partial frame is retained and filling resumes at the same wr_idx, with no timeout.
- frame_ready while frame_valid=0 is ignored.
- Reset mid-operation: all partial and full frames are discarded and the block returns to its reset state.
- Data is stored unmodified (no scaling or rounding); the sign is preserved bit-exact.

Optional Feature:
Macro FRAME_BITREV_EN.
- Defined: sample with arrival index k is written to slot bitrev(k) over LOG2_LEN bits. Example for 16 samples: k=1 goes to slot 8, k=3 to slot 12. This gives the FFT its input in bit-reversed order.
- Undefined: sample k goes to slot k (natural order).
- Handshake, latency and overflow behaviour are identical in both builds.

Test Plan:
1. Ramp: fir_valid=1 for 16 cycles with fir_d=0..15 and frame_ready=0 -> frame_valid=1 after the 16th edge. Slot i = i, or bitrev(i) with FRAME_BITREV_EN (slot 8 = 1, slot 15 = 15). overflow=0.
2. Ping-pong: 32 continuous samples 0..31 with frame_ready=0 -> frame_valid stays 1 with frame 0..15. Pulse frame_ready once -> next cycle frame_data = 16..31, frame_valid=1. Pulse again -> frame_valid=0.
3. Overflow: 33 samples with frame_ready=0 -> 33rd sample (value 32) dropped, overflow=1. After two handshakes and 16 new samples, the frame contains only the new values; overflow is still 1.
4. Gaps and sign: 16 samples of 0x8000, 0x7FFF alternating, with fir_valid low on every third cycle -> frame completes after the 16th accepted sample with exact values. Slot pattern is 0x8000/0x7FFF in natural order.
5. Simultaneous: bank A presented; handshake on the same edge as the 16th sample of bank B -> frame_valid stays 1 and frame_data = B next cycle. No sample is lost.
6. Reset mid-frame: 7 samples, then rst pulse asynchronous to clk -> frame_valid=0 and overflow=0 immediately. The next 16 samples form a frame beginning at slot 0.

Source files
------------

// File: rtl/fir_frame_buffer.sv
// fir_frame_buffer: packs the FIR output stream into FRAME_LEN-sample frames
// for the downstream FFT. Two banks run ping-pong so filling continues while
// the FFT holds the previous frame; frames leave over a valid/ready handshake.
// Optional macro FRAME_BITREV_EN: store sample k at slot bitrev(k) instead of k.
module fir_frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 16,
    parameter int LOG2_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fir_valid,
    input  logic [DATA_W-1:0]             fir_d,
    input  logic                          frame_ready,
    output logic                          frame_valid,
    output logic [DATA_W*FRAME_LEN-1:0]   frame_data,
    output logic                          overflow
);

    logic [DATA_W-1:0]           bank0     [FRAME_LEN];
    logic [DATA_W-1:0]           bank1     [FRAME_LEN];
    logic [DATA_W-1:0]           bank0_nxt [FRAME_LEN];
    logic [DATA_W-1:0]           bank1_nxt [FRAME_LEN];
    logic [1:0]                  full, full_nxt;
    logic                        wr_bank, wr_bank_nxt;
    logic                        rd_bank, rd_bank_nxt;
    logic [LOG2_LEN-1:0]         wr_idx, wr_idx_nxt;
    logic [LOG2_LEN-1:0]         slot;
    logic                        overflow_nxt;
    logic                        frame_valid_nxt;
    logic [DATA_W*FRAME_LEN-1:0] frame_data_nxt;
    logic                        accept;
    logic                        handshake;

    // Map the arrival index to its storage slot.
    always_comb begin
`ifdef FRAME_BITREV_EN
        slot = '0;
        for (int b = 0; b < LOG2_LEN; b++) begin
            slot[b] = wr_idx[LOG2_LEN-1-b];
        end
`else
        slot = wr_idx;
`endif
    end

    // Next-state of banks, flags and pointers. Accept/drop decisions use the
    // pre-edge full flags, so a bank freed by a handshake is only writable
    // from the following cycle. The outputs are derived from the next state
    // so frame_valid/frame_data update on the edge that completes a frame.
    always_comb begin
        bank0_nxt   = bank0;
        bank1_nxt   = bank1;
        full_nxt    = full;
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;
        wr_idx_nxt  = wr_idx;

        accept       = fir_valid && !full[wr_bank];
        handshake    = frame_valid && frame_ready;
        overflow_nxt = overflow || (fir_valid && full[wr_bank]);

        if (accept) begin
            if (wr_bank) bank1_nxt[slot] = fir_d;
            else         bank0_nxt[slot] = fir_d;
            if (wr_idx == LOG2_LEN'(FRAME_LEN - 1)) begin
                full_nxt[wr_bank] = 1'b1;
                wr_idx_nxt        = '0;
                wr_bank_nxt       = ~wr_bank;
            end else begin
                wr_idx_nxt = wr_idx + LOG2_LEN'(1);
            end
        end

        if (handshake) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
        end

        frame_valid_nxt = full_nxt[rd_bank_nxt];
        frame_data_nxt  = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            frame_data_nxt[i*DATA_W +: DATA_W] = rd_bank_nxt ? bank1_nxt[i] : bank0_nxt[i];
        end
    end

    // State and registered outputs; reset discards every frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_idx      <= '0;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else begin
            bank0       <= bank0_nxt;
            bank1       <= bank1_nxt;
            full        <= full_nxt;
            wr_bank     <= wr_bank_nxt;
            rd_bank     <= rd_bank_nxt;
            wr_idx      <= wr_idx_nxt;
            overflow    <= overflow_nxt;
            frame_valid <= frame_valid_nxt;
            frame_data  <= frame_data_nxt;
        end
    end

endmodule
